// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store unit bridging the pipeline to a request/grant data bus
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] RESET_RDATA    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [2:0]  funct3M,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_be,
   input  logic        dbus_gnt,
   input  logic        dbus_rvalid,
   input  logic [31:0] dbus_rdata,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        RegWriteMOut,
   output logic        FaultM
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   // Fault fires in the WAIT_R cycle that would complete TIMEOUT_CYCLES cycles without rvalid
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;

   logic        op, illegal, misaligned, fault;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc, rshift, load_ext;

   // Decode the M-stage request: size legality, alignment, lane enables and replicated store data
   always_comb begin
      op         = MemWriteM | (ResultSrcM == 2'b01);
      illegal    = (funct3M == 3'b011) || (funct3M == 3'b110) || (funct3M == 3'b111);
      misaligned = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                   ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
      be_calc    = 4'b1111;
      wdata_calc = WriteDataM;
      case (funct3M[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << ALUResultM[1:0];
            wdata_calc = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            be_calc    = 4'b0011 << ALUResultM[1:0];
            wdata_calc = {2{WriteDataM[15:0]}};
         end
         default: ;
      endcase
   end

   // Align the returned word to the captured byte offset and extend per the captured load size
   always_comb begin
      rshift   = dbus_rdata >> {off_q, 3'b000};
      load_ext = dbus_rdata;
      case (f3_q)
         3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
         3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
         3'b100:  load_ext = {24'h0, rshift[7:0]};
         3'b101:  load_ext = {16'h0, rshift[15:0]};
         default: load_ext = dbus_rdata;
      endcase
   end

   // Next-state logic; bus outputs are latched on leaving IDLE so they stay stable until grant
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      fault   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (op) begin
               if (illegal || misaligned) begin
                  fault = 1'b1;
               end else begin
                  req_d   = 1'b1;
                  we_d    = MemWriteM;
                  addr_d  = {ALUResultM[31:2], 2'b00};
                  wdata_d = wdata_calc;
                  be_d    = be_calc;
                  f3_d    = funct3M;
                  off_d   = ALUResultM[1:0];
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (dbus_gnt) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = we_q ? DONE : WAIT_R;
            end
         end
         WAIT_R: begin
            if (dbus_rvalid) begin
               rdata_d = load_ext;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               fault   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered bus/read-data outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         rdata_q <= RESET_RDATA;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
      end
   end

   assign dbus_req     = req_q;
   assign dbus_we      = we_q;
   assign dbus_addr    = addr_q;
   assign dbus_wdata   = wdata_q;
   assign dbus_be      = be_q;
   assign ReadDataM    = rdata_q;
   assign FaultM       = fault & ~rst;
   assign StallM       = op & (state_q != DONE) & ~fault & ~rst;
   assign RegWriteMOut = RegWriteM & ~FaultM;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteM;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [2:0]  funct3M;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_gnt, dbus_rvalid;
   logic [31:0] dbus_rdata;
   logic [31:0] ReadDataM;
   logic        StallM, RegWriteMOut, FaultM;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .funct3M(funct3M), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_gnt(dbus_gnt),
      .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .ReadDataM(ReadDataM),
      .StallM(StallM), .RegWriteMOut(RegWriteMOut), .FaultM(FaultM)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic op_set(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
      MemWriteM  = we;
      ResultSrcM = rs;
      funct3M    = f3;
      ALUResultM = a;
      WriteDataM = d;
   endtask

   initial begin
      int n;
      logic stall_drop;
      rst = 1'b1; RegWriteM = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
      op_set(1'b1, 2'b00, 3'b010, 32'h1000_0004, 32'h1111_2222);
      adv(); adv();
      @(negedge clk);
      chk("rst_req", dbus_req, 1'b0);
      chk("rst_stall", StallM, 1'b0);
      chk("rst_fault", FaultM, 1'b0);
      chk("rst_rdata", ReadDataM, 32'h0000_0000);
      chk("rst_addr", dbus_addr, 32'h0);
      chk("rst_be", dbus_be, 4'h0);

      // sw, immediate grant (grant already high in IDLE must be ignored)
      adv();
      rst = 1'b0; dbus_gnt = 1'b1;
      op_set(1'b1, 2'b00, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("sw_idle_stall", StallM, 1'b1);
      chk("sw_idle_req", dbus_req, 1'b0);
      adv(); @(negedge clk);
      chk("sw_req", dbus_req, 1'b1);
      chk("sw_we", dbus_we, 1'b1);
      chk("sw_be", dbus_be, 4'b1111);
      chk("sw_wdata", dbus_wdata, 32'hDEAD_BEEF);
      chk("sw_addr", dbus_addr, 32'h1000_0004);
      chk("sw_req_stall", StallM, 1'b1);
      adv(); @(negedge clk);
      chk("sw_done_stall", StallM, 1'b0);
      chk("sw_done_req", dbus_req, 1'b0);
      adv();
      op_set(1'b0, 2'b00, 3'b000, 32'h0, 32'h0); dbus_gnt = 1'b0;

      // lb at offset 3, grant delayed 3 cycles, stray rvalid in REQ ignored
      op_set(1'b0, 2'b01, 3'b000, 32'h1000_0003, 32'h0);
      @(negedge clk);
      chk("lb_idle_stall", StallM, 1'b1);
      adv();
      dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lb_wait_req", dbus_req, 1'b1);
         chk("lb_wait_addr", dbus_addr, 32'h1000_0000);
         chk("lb_wait_be", dbus_be, 4'b1000);
         chk("lb_wait_stall", StallM, 1'b1);
         adv();
      end
      dbus_rvalid = 1'b0; dbus_gnt = 1'b1;
      @(negedge clk);
      chk("lb_gnt_req", dbus_req, 1'b1);
      chk("lb_gnt_we", dbus_we, 1'b0);
      adv();
      dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h80FF_FFFF;
      @(negedge clk);
      chk("lb_waitr_req", dbus_req, 1'b0);
      chk("lb_waitr_stall", StallM, 1'b1);
      adv();
      dbus_rvalid = 1'b0;
      @(negedge clk);
      chk("lb_rdata", ReadDataM, 32'hFFFF_FF80);
      chk("lb_done_stall", StallM, 1'b0);
      adv();
      op_set(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);

      // lhu at offset 2, minimum latency (3 stall cycles then DONE)
      op_set(1'b0, 2'b01, 3'b101, 32'h1000_0002, 32'h0); dbus_gnt = 1'b1;
      @(negedge clk);
      chk("lhu_s1", StallM, 1'b1);
      adv(); @(negedge clk);
      chk("lhu_s2", StallM, 1'b1);
      chk("lhu_be", dbus_be, 4'b1100);
      adv();
      dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h8001_0000;
      @(negedge clk);
      chk("lhu_s3", StallM, 1'b1);
      adv();
      dbus_rvalid = 1'b0;
      @(negedge clk);
      chk("lhu_done_stall", StallM, 1'b0);
      chk("lhu_rdata", ReadDataM, 32'h0000_8001);
      adv();
      op_set(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);

      // sb at offset 2: byte replicated, single lane enabled
      op_set(1'b1, 2'b00, 3'b000, 32'h2000_0006, 32'h1234_56A5); dbus_gnt = 1'b1;
      adv(); @(negedge clk);
      chk("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
      chk("sb_be", dbus_be, 4'b0100);
      chk("sb_addr", dbus_addr, 32'h2000_0004);
      adv(); adv();
      op_set(1'b0, 2'b00, 3'b000, 32'h0, 32'h0); dbus_gnt = 1'b0;

      // sh misaligned: fault pulse, no request, no stall, write-back suppressed
      RegWriteM = 1'b1;
      op_set(1'b1, 2'b00, 3'b001, 32'h1000_0001, 32'h0000_BEEF);
      @(negedge clk);
      chk("sh_fault", FaultM, 1'b1);
      chk("sh_stall", StallM, 1'b0);
      chk("sh_regwr", RegWriteMOut, 1'b0);
      adv();
      op_set(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk("sh_fault_clr", FaultM, 1'b0);
      chk("sh_no_req", dbus_req, 1'b0);
      chk("sh_regwr_pass", RegWriteMOut, 1'b1);
      RegWriteM = 1'b0;

      // illegal funct3 load
      adv();
      op_set(1'b0, 2'b01, 3'b011, 32'h1000_0000, 32'h0);
      @(negedge clk);
      chk("ill_fault", FaultM, 1'b1);
      adv();
      op_set(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk("ill_no_req", dbus_req, 1'b0);

      // lw timeout: grant, then no rvalid; fault lands in the 255th WAIT_R cycle
      adv();
      op_set(1'b0, 2'b01, 3'b010, 32'h1000_0008, 32'h0); dbus_gnt = 1'b1;
      adv(); @(negedge clk);
      chk("to_req", dbus_req, 1'b1);
      adv();
      dbus_gnt = 1'b0;
      n = 0; stall_drop = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (FaultM) begin
            n = k;
            break;
         end
         if (!StallM) stall_drop = 1'b1;
         adv();
      end
      chk("to_cycles", n, 255);
      chk("to_stall_held", stall_drop, 1'b0);
      chk("to_fault_stall", StallM, 1'b0);
      chk("to_rdata_kept", ReadDataM, 32'h0000_8001);
      adv(); @(negedge clk);
      chk("to_done_fault", FaultM, 1'b0);
      chk("to_done_stall", StallM, 1'b0);
      adv();
      op_set(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk("to_idle_req", dbus_req, 1'b0);

      // reset during WAIT_R, late rvalid afterwards must be ignored
      adv();
      op_set(1'b0, 2'b01, 3'b010, 32'h1000_000C, 32'h0); dbus_gnt = 1'b1;
      adv(); adv();
      dbus_gnt = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("rw_rst_stall", StallM, 1'b0);
      adv();
      rst = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFE_F00D;
      op_set(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk("rw_rdata", ReadDataM, 32'h0000_0000);
      chk("rw_req", dbus_req, 1'b0);
      chk("rw_addr", dbus_addr, 32'h0);
      chk("rw_fault", FaultM, 1'b0);
      adv();
      dbus_rvalid = 1'b0;
      @(negedge clk);
      chk("rw_late_rdata", ReadDataM, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
